// File: rtl/tinyalu_pkg.sv
// Shared types and widths for the tinyalu memory path.
package tinyalu_pkg;

    localparam int unsigned MEM_ADDR_W  = 14;
    localparam int unsigned MEM_WDATA_W = 16;
    localparam int unsigned MEM_RDATA_W = 8;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;
    typedef enum logic {MEM_OP_LOAD, MEM_OP_STORE} mem_op_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         eligible_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [$clog2(NREQ)-1:0] winner_o,
    output logic                    found_o
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        cand     = '0;
        winner_o = '0;
        found_o  = 1'b0;
        // Walk from the farthest offset back so the nearest eligible requester wins.
        for (int off = int'(NREQ) - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr_i) + off) % int'(NREQ));
            if (eligible_i[cand]) begin
                winner_o = cand;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one MIU among NREQ load/store requesters, with a GRANT watchdog.
module mem_req_arbiter
    import tinyalu_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req_load,
    input  logic [NREQ-1:0]               req_store,
    input  logic [NREQ*MEM_ADDR_W-1:0]    req_addr,
    input  logic [NREQ*MEM_WDATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]               req_done,
    output logic [NREQ-1:0]               req_err,
    output logic [MEM_RDATA_W-1:0]        req_rdata,
    output logic                          mem_load,
    output logic                          mem_store,
    output logic [MEM_ADDR_W-1:0]         mem_addr,
    output logic [MEM_WDATA_W-1:0]        mem_wdata,
    input  logic [MEM_RDATA_W-1:0]        mem_rdata,
    input  logic                          mem_done,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       grant_id
);

    localparam int unsigned IDX_W  = $clog2(NREQ);
    localparam int unsigned WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t               state_q, state_d;
    mem_op_t                  op_q, op_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         grant_id_q, grant_id_d;
    logic [WDOG_W-1:0]        wdog_q, wdog_d;
    logic [NREQ-1:0]          req_done_q, req_done_d;
    logic [NREQ-1:0]          req_err_q, req_err_d;
    logic [MEM_RDATA_W-1:0]   req_rdata_q, req_rdata_d;
    logic                     mem_load_q, mem_load_d;
    logic                     mem_store_q, mem_store_d;
    logic [MEM_ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [MEM_WDATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                     busy_q, busy_d;

    logic [NREQ-1:0]          eligible;
    logic [IDX_W-1:0]         winner;
    logic                     found;
    logic                     wdog_hit;
    logic [MEM_ADDR_W-1:0]    addr_arr  [NREQ];
    logic [MEM_WDATA_W-1:0]   wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*MEM_ADDR_W +: MEM_ADDR_W];
        assign wdata_arr[g] = req_wdata[g*MEM_WDATA_W +: MEM_WDATA_W];
    end

    assign eligible = req_load | req_store;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (winner),
        .found_o    (found)
    );

    // wdog_q counts completed GRANT cycles, so +1 is the index of the current one.
    assign wdog_hit = (TIMEOUT != 0) && ((32'(wdog_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        wdog_d      = wdog_q;
        req_done_d  = '0;
        req_err_d   = '0;
        req_rdata_d = req_rdata_q;
        mem_load_d  = mem_load_q;
        mem_store_d = mem_store_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    wdog_d     = '0;
                    if (req_load[winner] && req_store[winner]) begin
                        req_err_d[winner] = 1'b1;
                        state_d           = ARB_RELEASE;
                    end else begin
                        op_d        = req_store[winner] ? MEM_OP_STORE : MEM_OP_LOAD;
                        mem_load_d  = req_load[winner];
                        mem_store_d = req_store[winner];
                        mem_addr_d  = addr_arr[winner];
                        mem_wdata_d = wdata_arr[winner];
                        state_d     = ARB_GRANT;
                    end
                end
            end
            ARB_GRANT: begin
                wdog_d = wdog_q + 1'b1;
                if (mem_done) begin
                    req_done_d[grant_id_q] = 1'b1;
                    if (op_q == MEM_OP_LOAD) begin
                        req_rdata_d = mem_rdata;
                    end
                    mem_load_d  = 1'b0;
                    mem_store_d = 1'b0;
                    state_d     = ARB_RELEASE;
                end else if (wdog_hit) begin
                    req_err_d[grant_id_q] = 1'b1;
                    mem_load_d            = 1'b0;
                    mem_store_d           = 1'b0;
                    state_d               = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                ptr_d   = (grant_id_q == IDX_W'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            op_q        <= MEM_OP_LOAD;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            wdog_q      <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
            req_rdata_q <= '0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            wdog_q      <= wdog_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            req_rdata_q <= req_rdata_d;
            mem_load_q  <= mem_load_d;
            mem_store_q <= mem_store_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign req_rdata = req_rdata_q;
    assign mem_load  = mem_load_q;
    assign mem_store = mem_store_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: model predicts accesses and responses, monitor compares.
module tb_mem_req_arbiter;
    import tinyalu_pkg::*;

    localparam int NREQ = 3;
    localparam int TO   = 4;

    logic                        clk;
    logic                        reset_n;
    logic [NREQ-1:0]             req_load, req_store;
    logic [NREQ*MEM_ADDR_W-1:0]  req_addr;
    logic [NREQ*MEM_WDATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             req_done, req_err;
    logic [7:0]                  req_rdata;
    logic                        mem_load, mem_store;
    logic [13:0]                 mem_addr;
    logic [15:0]                 mem_wdata;
    logic [7:0]                  mem_rdata;
    logic                        mem_done;
    logic                        busy;
    logic [1:0]                  grant_id;

    mem_req_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_load  (req_load),
        .req_store (req_store),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .mem_load  (mem_load),
        .mem_store (mem_store),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        int          id;
        logic        store;
        logic [13:0] addr;
        logic [15:0] wdata;
        int          len;
    } acc_t;

    typedef struct {
        int         id;
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    acc_t       acc_q[$];
    rsp_t       rsp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         model_ptr   = 0;
    logic [7:0] model_rdata = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL global_timeout: got no end of test, want finish within 50000 cycles");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string name, input logic ok, input string got, input string want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    task automatic set_req(input int i, input logic ld, input logic st,
                           input logic [13:0] a, input logic [15:0] wd);
        req_load[i]               = ld;
        req_store[i]              = st;
        req_addr[i*14 +: 14]      = a;
        req_wdata[i*16 +: 16]     = wd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp"}, (req_done == '0) && (req_err == '0) && (req_rdata == '0),
            $sformatf("done=%b err=%b rdata=%h", req_done, req_err, req_rdata), "all zero");
        chk({tag, "_mem"}, !mem_load && !mem_store && mem_addr == '0 && mem_wdata == '0,
            $sformatf("ld=%b st=%b addr=%h wd=%h", mem_load, mem_store, mem_addr, mem_wdata),
            "all zero");
        chk({tag, "_stat"}, !busy && grant_id == '0,
            $sformatf("busy=%b gid=%0d", busy, grant_id), "busy=0 gid=0");
    endtask

    // Entered at the falling edge of an idle cycle with requests driven; returns at the
    // falling edge of the next idle cycle with the served requester's request dropped.
    // k is the GRANT cycle (1-based) on which the MIU raises mem_done.
    task automatic round(input int k, input logic [7:0] rd);
        logic [NREQ-1:0] elig;
        int   w, resp_cyc;
        logic ill;
        acc_t a;
        rsp_t r;
        elig = req_load | req_store;
        w    = -1;
        for (int off = 0; off < NREQ && w < 0; off++) begin
            if (elig[(model_ptr + off) % NREQ]) w = (model_ptr + off) % NREQ;
        end
        if (w < 0) return;
        ill  = req_load[w] && req_store[w];
        r.id = w;
        if (ill) begin
            r.err    = 1'b1;
            r.rdata  = model_rdata;
            resp_cyc = 1;
        end else begin
            a.id    = w;
            a.store = req_store[w];
            a.addr  = req_addr[w*14 +: 14];
            a.wdata = req_wdata[w*16 +: 16];
            a.len   = (k <= TO) ? k : TO;
            acc_q.push_back(a);
            if (k <= TO) begin
                if (!a.store) model_rdata = rd;
                r.err    = 1'b0;
                resp_cyc = k + 1;
            end else begin
                r.err    = 1'b1;
                resp_cyc = TO + 1;
            end
            r.rdata = model_rdata;
        end
        rsp_q.push_back(r);
        model_ptr = (w + 1) % NREQ;
        for (int c = 1; c <= resp_cyc + 1; c++) begin
            @(negedge clk);
            mem_done  = !ill && (c == k);
            mem_rdata = (c == k) ? rd : 8'($urandom);
            if (c == resp_cyc) begin
                req_load[w]  = 1'b0;
                req_store[w] = 1'b0;
            end
        end
    endtask

    // Monitor: compares every access start and every done/err pulse against the queues.
    initial begin
        logic            act, act_prev;
        int              run_len, exp_len;
        acc_t            ca;
        rsp_t            cr;
        logic [NREQ-1:0] exp_done, exp_err;
        act_prev = 1'b0;
        run_len  = 0;
        exp_len  = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                act_prev = 1'b0;
                run_len  = 0;
            end else begin
                act = mem_load | mem_store;
                if (act && !act_prev) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_access", 1'b0, $sformatf("access by gid=%0d", grant_id),
                            "no access");
                    end else begin
                        ca      = acc_q.pop_front();
                        exp_len = ca.len;
                        run_len = 0;
                        chk("acc_op", mem_store == ca.store && mem_load == !ca.store && busy,
                            $sformatf("ld=%b st=%b busy=%b", mem_load, mem_store, busy),
                            $sformatf("ld=%b st=%b busy=1", !ca.store, ca.store));
                        chk("acc_addr", mem_addr == ca.addr && grant_id == 2'(ca.id),
                            $sformatf("addr=%h gid=%0d", mem_addr, grant_id),
                            $sformatf("addr=%h gid=%0d", ca.addr, ca.id));
                        if (ca.store) begin
                            chk("acc_wdata", mem_wdata == ca.wdata, $sformatf("%h", mem_wdata),
                                $sformatf("%h", ca.wdata));
                        end
                    end
                end
                if (act) run_len++;
                if (!act && act_prev) begin
                    chk("acc_len", run_len == exp_len, $sformatf("%0d cycles", run_len),
                        $sformatf("%0d cycles", exp_len));
                end
                act_prev = act;
                if ((req_done | req_err) != '0) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rsp", 1'b0,
                            $sformatf("done=%b err=%b", req_done, req_err), "no response");
                    end else begin
                        cr       = rsp_q.pop_front();
                        exp_done = '0;
                        exp_err  = '0;
                        if (cr.err) exp_err[cr.id] = 1'b1;
                        else        exp_done[cr.id] = 1'b1;
                        chk("rsp_vec", req_done == exp_done && req_err == exp_err,
                            $sformatf("done=%b err=%b", req_done, req_err),
                            $sformatf("done=%b err=%b", exp_done, exp_err));
                        chk("rsp_rdata", req_rdata == cr.rdata && grant_id == 2'(cr.id),
                            $sformatf("rdata=%h gid=%0d", req_rdata, grant_id),
                            $sformatf("rdata=%h gid=%0d", cr.rdata, cr.id));
                    end
                end
            end
        end
    end

    initial begin
        int   sel;
        acc_t a;
        reset_n   = 1'b0;
        req_load  = '0;
        req_store = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_done  = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Contention from reset: req0 load first, then req1 store.
        set_req(0, 1'b1, 1'b0, 14'h011, 16'h0000);
        set_req(1, 1'b0, 1'b1, 14'h012, 16'hBEEF);
        round(2, 8'h5A);
        round(1, 8'h77);
        // Both keep re-requesting: grants alternate.
        for (int n = 0; n < 4; n++) begin
            set_req(0, 1'b1, 1'b0, 14'h011, 16'h0000);
            set_req(1, 1'b0, 1'b1, 14'h012, 16'hBEEF);
            round(1 + n % 3, 8'(8'h10 + n));
        end
        req_load  = '0;
        req_store = '0;

        // Single load.
        set_req(0, 1'b1, 1'b0, 14'h010, 16'h0000);
        round(3, 8'hA5);
        // Illegal request on req1, then req0 is served.
        set_req(1, 1'b1, 1'b1, 14'h020, 16'h1234);
        round(1, 8'h00);
        set_req(0, 1'b0, 1'b1, 14'h030, 16'hCAFE);
        round(2, 8'hEE);
        // Timeout with late spurious mem_done, then done on exactly the last cycle.
        set_req(0, 1'b1, 1'b0, 14'h040, 16'h0000);
        round(TO + 2, 8'h99);
        set_req(2, 1'b1, 1'b0, 14'h041, 16'h0000);
        round(TO + 1, 8'h98);
        set_req(0, 1'b1, 1'b0, 14'h042, 16'h0000);
        round(TO, 8'h3E);

        // Randomized traffic; unserved requesters keep holding their requests.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_load[i] | req_store[i]) && $urandom_range(0, 1) == 1) begin
                    sel = $urandom_range(0, 9);
                    set_req(i, (sel >= 3 && sel <= 5) || sel == 9, sel >= 6,
                            14'($urandom), 16'($urandom));
                end
            end
            if ((req_load | req_store) == '0) begin
                set_req($urandom_range(0, NREQ - 1), 1'b1, 1'b0, 14'($urandom), 16'($urandom));
            end
            round($urandom_range(1, TO + 2), 8'($urandom));
        end
        req_load  = '0;
        req_store = '0;

        // Reset in the middle of a grant abandons it and returns the pointer to 0.
        set_req(0, 1'b1, 1'b0, 14'h050, 16'h0000);
        round(2, 8'h61);
        set_req(1, 1'b1, 1'b0, 14'h051, 16'h0000);
        a.id    = 1;
        a.store = 1'b0;
        a.addr  = 14'h051;
        a.wdata = '0;
        a.len   = 0;
        acc_q.push_back(a);
        mem_done = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        req_load  = '0;
        req_store = '0;
        #1 reset_n = 1'b1;
        model_ptr   = 0;
        model_rdata = '0;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 14'h060, 16'h0000);
        set_req(1, 1'b1, 1'b0, 14'h061, 16'h0000);
        round(1, 8'hC3);
        round(2, 8'h3C);

        mem_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("acc_queue_empty", acc_q.size() == 0, $sformatf("%0d left", acc_q.size()), "0 left");
        chk("rsp_queue_empty", rsp_q.size() == 0, $sformatf("%0d left", rsp_q.size()), "0 left");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
